// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Kept separate so a future receiver can reuse the same encoding.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// The clear input restarts the count so that every new state begins a full bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  // Count register: cleared by reset or a state change, wraps at the end of a bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining 8N1 UART transmitter. Pops one byte per frame from a FIFO
// with one-cycle registered read latency and serialises it LSB first on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int  CLKS_PER_BIT = 104,
  parameter int  FIFO_SIZE    = 128,
  localparam int FILL_BITS    = $clog2(FIFO_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [FILL_BITS-1:0] fifo_fill,
  output logic                 rd_en,
  input  logic [7:0]           rd_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  uart_state_t               state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [2:0]                bit_idx_reg, bit_idx_next;
  logic                      tx_reg, tx_next;
  logic                      pop_next;
  logic                      tick;
  logic                      baud_clear;

  // Every state change restarts the bit timer so each phase lasts a full bit.
  assign baud_clear = (state_next != state_reg);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // State, shift register, bit index and line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  // Next-state logic; the line level is decoded from the next state so tx is registered.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    pop_next     = 1'b0;
    tx_next      = 1'b1;

    case (state_reg)
      IDLE: begin
        // Only IDLE may pop, so a late-updating fifo_fill can never cause a second read.
        if (enable && (fifo_fill != '0)) begin
          pop_next   = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        // rd_data is valid now, one cycle after the read strobe.
        shift_next = rd_data;
        state_next = START;
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            shift_next   = shift_reg >> 1;
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  // Handshake and status decoded from registered state; reset masks them all.
  assign rd_en   = pop_next && !rst;
  assign busy    = !rst && ((state_reg != IDLE) || pop_next);
  assign tx_done = !rst && (state_reg == STOP) && tick;
  assign tx      = tx_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO (registered read).
module tb_fifo_uart_tx;

  localparam int CPB       = 4;
  localparam int FSIZE     = 16;
  localparam int FILL_BITS = $clog2(FSIZE);

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [FILL_BITS-1:0] fifo_fill;
  logic                 rd_en;
  logic [7:0]           rd_data;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  int checks   = 0;
  int failures = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  logic rd_en_seen = 1'b0;

  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = line level in bit time i (0 = start, 9 = stop)
    int         gap;
  } vec_t;

  vec_t vecs[5];

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_SIZE   (FSIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .fifo_fill(fifo_fill),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle monitor: inputs settle at the falling edge, so sample 2 units later.
  always @(negedge clk) begin
    #2;
    rd_en_seen = rd_en;
    if (rd_en === 1'b1) rd_cnt++;
    if (tx_done === 1'b1) done_cnt++;
  end

  // FIFO model: data appears on rd_data the cycle after a strobe.
  always @(posedge clk) begin
    if (rd_en_seen && q.size() != 0) begin
      rd_data   <= q.pop_front();
      fifo_fill <= FILL_BITS'(q.size());
    end
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_fill <= FILL_BITS'(q.size());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Waits for the start bit, then checks every cycle of the frame. Called at a falling edge.
  task automatic receive_frame(input logic [9:0] frame, input int exp_gap, input string name);
    int gap = 0;
    int wave_err = 0;
    int done_err = 0;
    int busy_err = 0;
    int rd_err = 0;
    logic exp_done;
    while (tx !== 1'b0 && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    check({name, "_gap"}, 32'(gap), 32'(exp_gap));
    if (gap >= 100) return;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_done = (i == 9) && (c == CPB - 1);
        if (tx !== frame[i]) wave_err++;
        if (tx_done !== exp_done) done_err++;
        if (busy !== 1'b1) busy_err++;
        if (rd_en !== 1'b0) rd_err++;
        @(negedge clk);
      end
    end
    check({name, "_wave_errs"}, 32'(wave_err), 32'd0);
    check({name, "_done_errs"}, 32'(done_err), 32'd0);
    check({name, "_busy_errs"}, 32'(busy_err), 32'd0);
    check({name, "_rd_en_errs"}, 32'(rd_err), 32'd0);
    $display("frame %s gap=%0d wave_errs=%0d", name, gap, wave_err);
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    enable    = 1'b1;
    rd_data   = 8'h00;
    fifo_fill = '0;

    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010, gap: 2};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000, gap: 2};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110, gap: 2};
    vecs[3] = '{data: 8'h55, frame: 10'b1010101010, gap: 2};
    vecs[4] = '{data: 8'h42, frame: 10'b1010000100, gap: 2};

    for (int k = 0; k < 5; k++) push(vecs[k].data);

    // Reset held 3 cycles with data available and enable high.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_rd_en", 32'(rd_en), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("first_rd_en", 32'(rd_en), 32'd1);
    check("first_busy", 32'(busy), 32'd1);

    // Table: five queued bytes drain back to back.
    for (int k = 0; k < 5; k++) begin
      receive_frame(vecs[k].frame, vecs[k].gap, $sformatf("vec%0d_%02h", k, vecs[k].data));
    end
    check("drain_fill", 32'(fifo_fill), 32'd0);
    check("drain_rd_cnt", 32'(rd_cnt), 32'd5);
    check("drain_done_cnt", 32'(done_cnt), 32'd5);
    check("drain_busy", 32'(busy), 32'd0);

    // Empty FIFO: line stays idle and nothing is popped.
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (tx !== 1'b1 || rd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    check("empty_idle_errs", 32'(bad), 32'd0);
    check("empty_rd_cnt", 32'(rd_cnt), 32'd5);
    $display("empty fifo idle 200 cycles errs=%0d", bad);

    // Enable dropped during the data bits of 0x3C with two bytes behind it.
    push(8'h3C);
    push(8'h81);
    push(8'h42);
    fork
      receive_frame(10'b1001111000, 2, "en_drop_3C");
      begin
        repeat (12) @(negedge clk);
        enable = 1'b0;
      end
    join
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx !== 1'b1 || rd_en !== 1'b0) bad++;
      @(negedge clk);
    end
    check("disabled_idle_errs", 32'(bad), 32'd0);
    check("disabled_fill", 32'(fifo_fill), 32'd2);
    check("disabled_rd_cnt", 32'(rd_cnt), 32'd6);
    $display("enable low hold errs=%0d fill=%0d", bad, fifo_fill);

    // Re-enable: 0x81 starts, reset lands in its bit 4.
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check("r81_bit0", 32'(tx), 32'd1);
    repeat (17) @(negedge clk);
    check("r81_bit4", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(rd_en), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_rd_en", 32'(rd_en), 32'd1);
    $display("reset during 0x81 bit4 tx=%0b", tx);
    receive_frame(10'b1010000100, 2, "after_rst_42");

    check("final_fill", 32'(fifo_fill), 32'd0);
    check("final_rd_cnt", 32'(rd_cnt), 32'd8);
    check("final_done_cnt", 32'(done_cnt), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
